pll_seq_ctrl: RTL

Power-up and recovery sequencer for the Gowin PLL clock generator. It runs on the free-running 50 MHz board clock that also feeds the PLL reference input. The block:
- pulses the PLL reset and qualifies its `lock` output;
- gates the three PLL output clocks on one at a time through their `enclk` inputs;
- releases a per-domain synchronous reset to the audio, SD and system logic;
- restarts the whole sequence on lock loss, lock timeout or software request.

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/pll_seq_ctrl_sync2.sv | 24 ++
 rtl/pll_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state type and default timing for the PLL power-up sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    ENABLE,
    RELEASE,
    RUN
  } pll_seq_state_t;

  localparam int ENCLK_N = 3;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_ENABLE_GAP    = 8;
  localparam int DEF_RST_HOLD      = 16;
  localparam int DEF_CNT_W         = 8;

  function automatic int max_of5(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/pll_seq_ctrl_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_seq_ctrl.sv
// Power-up and lock-recovery sequencer for the Gowin PLL clock generator.
// Define PLL_SEQ_STATUS_EN to build the retry/loss status counters.
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int ENABLE_GAP    = DEF_ENABLE_GAP,
  parameter int RST_HOLD      = DEF_RST_HOLD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_rst,
  output logic [ENCLK_N-1:0] enclk,
  output logic [ENCLK_N-1:0] dom_rst,
  output logic               ready,
  output logic [CNT_W-1:0]   retry_cnt,
  output logic [CNT_W-1:0]   loss_cnt
);

  localparam int TMR_W = $clog2(max_of5(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                        ENABLE_GAP, RST_HOLD)) + 1;

  localparam logic [TMR_W-1:0] T_RST  = TMR_W'(RST_CYCLES);
  localparam logic [TMR_W-1:0] T_LOCK = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] T_STB  = TMR_W'(STABLE_CYCLES);
  localparam logic [TMR_W-1:0] T_GAP  = TMR_W'(ENABLE_GAP);
  localparam logic [TMR_W-1:0] T_HOLD = TMR_W'(RST_HOLD);
  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);

  pll_seq_state_t     state, state_next;
  logic [TMR_W-1:0]   tmr, tmr_next;
  logic               pll_rst_next, ready_next;
  logic [ENCLK_N-1:0] enclk_next, dom_rst_next;
  logic               lock_s;
  logic               tmr_last, lock_lost, abort;
  logic               retry_evt, loss_evt;

  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_PLL;
      tmr     <= T_RST;
      pll_rst <= 1'b1;
      enclk   <= '0;
      dom_rst <= '1;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      tmr     <= tmr_next;
      pll_rst <= pll_rst_next;
      enclk   <= enclk_next;
      dom_rst <= dom_rst_next;
      ready   <= ready_next;
    end
  end

  // Outputs are computed for the next state and registered alongside it,
  // so no input reaches a port without passing through a flop.
  always_comb begin
    state_next   = state;
    tmr_next     = tmr;
    pll_rst_next = pll_rst;
    enclk_next   = enclk;
    dom_rst_next = dom_rst;
    ready_next   = ready;
    retry_evt    = 1'b0;
    loss_evt     = 1'b0;
    tmr_last     = (tmr == T_ONE);
    lock_lost    = !lock_s && (state == ENABLE || state == RELEASE || state == RUN);
    abort        = lock_lost || (restart && state != RESET_PLL);

    if (abort) begin
      loss_evt     = lock_lost;
      state_next   = RESET_PLL;
      tmr_next     = T_RST;
      pll_rst_next = 1'b1;
      enclk_next   = '0;
      dom_rst_next = '1;
      ready_next   = 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (tmr_last) begin
            state_next   = WAIT_LOCK;
            tmr_next     = T_LOCK;
            pll_rst_next = 1'b0;
          end else begin
            tmr_next = tmr - T_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
            tmr_next   = T_STB;
          end else if (tmr_last) begin
            retry_evt    = 1'b1;
            state_next   = RESET_PLL;
            tmr_next     = T_RST;
            pll_rst_next = 1'b1;
          end else begin
            tmr_next = tmr - T_ONE;
          end
        end
        // A drop here only restarts the stable window; it is not a loss.
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
            tmr_next   = T_LOCK;
          end else if (tmr_last) begin
            state_next = ENABLE;
            tmr_next   = T_GAP;
            enclk_next = ENCLK_N'(1);
          end else begin
            tmr_next = tmr - T_ONE;
          end
        end
        ENABLE: begin
          if (!tmr_last) begin
            tmr_next = tmr - T_ONE;
          end else if (&enclk) begin
            state_next = RELEASE;
            tmr_next   = T_HOLD;
          end else begin
            enclk_next = {enclk[ENCLK_N-2:0], 1'b1};
            tmr_next   = T_GAP;
          end
        end
        // The timer parks at one while domain resets drop one per cycle.
        RELEASE: begin
          if (!tmr_last) begin
            tmr_next = tmr - T_ONE;
          end else begin
            dom_rst_next = {dom_rst[ENCLK_N-2:0], 1'b0};
            if (dom_rst_next == '0) begin
              state_next = RUN;
              ready_next = 1'b1;
            end
          end
        end
        RUN: begin
          ready_next = 1'b1;
        end
        default: begin
          state_next   = RESET_PLL;
          tmr_next     = T_RST;
          pll_rst_next = 1'b1;
          enclk_next   = '0;
          dom_rst_next = '1;
          ready_next   = 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_STATUS_EN
  logic [CNT_W-1:0] retry_q, loss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_evt && retry_q != '1) retry_q <= retry_q + CNT_W'(1);
      if (loss_evt && loss_q != '1)   loss_q  <= loss_q + CNT_W'(1);
    end
  end

  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
`else
  logic unused_evt;

  assign unused_evt = retry_evt | loss_evt;
  assign retry_cnt  = '0;
  assign loss_cnt   = '0;
`endif

endmodule
